// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Shares one UART transmitter between NREQ packet producers. A round-robin
// arbiter picks a requester, then the packet is streamed byte by byte into
// the transmitter's START/DATA/BUSY handshake. Each packet is framed as
// header byte (HDR_BASE | id), payload bytes, and an XOR checksum byte.
//
// Ports:
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset (deassertion synchronized)
//   REQ_VALID  per-requester byte available
//   REQ_DATA   byte of requester i at [8i+7:8i]
//   REQ_LAST   current byte is the final payload byte
//   REQ_ACK    one-cycle pulse: byte taken, present the next one
//   GNT        one-hot grant, held for the whole packet
//   ACTIVE     packet in progress
//   ERR        sticky: START timeout or MAX_LEN overrun
//   TX_START   transmitter START
//   TX_DATA    transmitter DATA
//   TX_BUSY    transmitter BUSY
module uart_tx_sched #(
   parameter int         NREQ     = 4,
   parameter logic [7:0] HDR_BASE = 8'hA0,
   parameter int         MAX_LEN  = 16,
   parameter int         START_TO = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [NREQ-1:0]   REQ_VALID,
   input  logic [8*NREQ-1:0] REQ_DATA,
   input  logic [NREQ-1:0]   REQ_LAST,
   output logic [NREQ-1:0]   REQ_ACK,
   output logic [NREQ-1:0]   GNT,
   output logic              ACTIVE,
   output logic              ERR,
   output logic              TX_START,
   output logic [7:0]        TX_DATA,
   input  logic              TX_BUSY
);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_PAY_WAIT, S_SEND_S, S_SEND_B, S_CSUM, S_DONE
   } state_t;

   // Which kind of byte is currently in flight; decides where SEND_B goes.
   typedef enum logic [1:0] {K_HDR, K_PAY, K_CSUM} kind_t;

   logic [1:0]      rst_sync_q, rst_sync_d;
   logic            rst_int_n;
   state_t          state_q, state_d;
   kind_t           kind_q, kind_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic            active_q, active_d;
   logic            err_q, err_d;
   logic            tx_start_q, tx_start_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [7:0]      csum_q, csum_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            last_q, last_d;
   logic [7:0]      to_cnt_q, to_cnt_d;

   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic [7:0]      cur_byte;
   logic [7:0]      hdr_byte;
   logic            at_max;
   logic            to_expired;

   // Reset asserts asynchronously and releases two clocks later.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rst_sync_q <= 2'b00;
      else        rst_sync_q <= rst_sync_d;
   end

   assign rst_int_n = rst_sync_q[1];

   // Round-robin search: first valid index starting at rr_q, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = IW'((32'(rr_q) + 32'(off)) % 32'(NREQ));
         if (!win_found && REQ_VALID[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign cur_byte   = REQ_DATA[{gidx_q, 3'b000} +: 8];
   assign hdr_byte   = HDR_BASE | 8'(gidx_q);
   assign at_max     = (cnt_q + 8'd1) == 8'(MAX_LEN);
   // START has been high START_TO cycles when this edge is reached without BUSY.
   assign to_expired = to_cnt_q == 8'(START_TO - 1);

   // State register and all datapath flops.
   always_ff @(posedge CLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= S_IDLE;
         kind_q     <= K_HDR;
         gnt_q      <= '0;
         gidx_q     <= '0;
         rr_q       <= '0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         ack_q      <= '0;
         csum_q     <= '0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         to_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         gnt_q      <= gnt_d;
         gidx_q     <= gidx_d;
         rr_q       <= rr_d;
         active_q   <= active_d;
         err_q      <= err_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         ack_q      <= ack_d;
         csum_q     <= csum_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         to_cnt_q   <= to_cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (!TX_BUSY && win_found) state_d = S_HDR;
         S_HDR:      state_d = S_SEND_S;
         S_SEND_S: begin
            if (TX_BUSY)         state_d = S_SEND_B;
            else if (to_expired) state_d = S_DONE;
         end
         S_SEND_B: begin
            if (!TX_BUSY) begin
               unique case (kind_q)
                  K_HDR:   state_d = S_PAY_WAIT;
                  K_PAY:   state_d = last_q ? S_CSUM : S_PAY_WAIT;
                  default: state_d = S_DONE;
               endcase
            end
         end
         S_PAY_WAIT: if (REQ_VALID[gidx_q]) state_d = S_SEND_S;
         S_CSUM:     state_d = S_SEND_S;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic.
   always_comb begin
      kind_d     = kind_q;
      gnt_d      = gnt_q;
      gidx_d     = gidx_q;
      rr_d       = rr_q;
      active_d   = active_q;
      err_d      = err_q;
      tx_start_d = tx_start_q;
      tx_data_d  = tx_data_q;
      ack_d      = '0;
      csum_d     = csum_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      to_cnt_d   = to_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (!TX_BUSY && win_found) begin
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               gidx_d         = win_idx;
               active_d       = 1'b1;
               csum_d         = '0;
               cnt_d          = '0;
               last_d         = 1'b0;
            end
         end
         S_HDR: begin
            tx_data_d  = hdr_byte;
            csum_d     = hdr_byte;
            tx_start_d = 1'b1;
            to_cnt_d   = '0;
            kind_d     = K_HDR;
         end
         S_SEND_S: begin
            if (TX_BUSY) begin
               tx_start_d = 1'b0;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
               if (to_expired) begin
                  tx_start_d = 1'b0;
                  err_d      = 1'b1;
               end
            end
         end
         S_PAY_WAIT: begin
            if (REQ_VALID[gidx_q]) begin
               tx_data_d     = cur_byte;
               csum_d        = csum_q ^ cur_byte;
               tx_start_d    = 1'b1;
               ack_d[gidx_q] = 1'b1;
               cnt_d         = cnt_q + 8'd1;
               to_cnt_d      = '0;
               kind_d        = K_PAY;
               // A full packet without LAST is closed here; the rest of the
               // requester's stream becomes a new packet.
               last_d        = REQ_LAST[gidx_q] | at_max;
               if (at_max && !REQ_LAST[gidx_q]) err_d = 1'b1;
            end
         end
         S_CSUM: begin
            tx_data_d  = csum_q;
            tx_start_d = 1'b1;
            to_cnt_d   = '0;
            kind_d     = K_CSUM;
         end
         S_DONE: begin
            gnt_d    = '0;
            active_d = 1'b0;
            rr_d     = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign REQ_ACK  = ack_q;
   assign GNT      = gnt_q;
   assign ACTIVE   = active_q;
   assign ERR      = err_q;
   assign TX_START = tx_start_q;
   assign TX_DATA  = tx_data_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Packet scheduler that shares the single UART transmitter between NREQ producers in the beamformer design. It arbitrates round-robin between requesters and streams each granted packet byte by byte into the transmitter's START/DATA/BUSY handshake. Every packet is framed with a source-ID header byte and a trailing XOR checksum byte. It sits between the beam/status producers and the UART TX, in the 100 MHz domain.

## Interface
- NREQ, 4: number of requesters, 2..8
- HDR_BASE, 8'hA0: header byte is HDR_BASE | requester index (low 3 bits must be 0 in HDR_BASE)
- MAX_LEN, 16: maximum payload bytes per packet, 1..255
- START_TO, 8: cycles TX_START may stay high without BUSY before a timeout, 2..255

Ports:
- CLK  in  1  system clock, 100 MHz, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ_VALID  in  NREQ  per-requester byte available
- REQ_DATA  in  8*NREQ  byte of requester i at [8i+7:8i]
- REQ_LAST  in  NREQ  current byte is the final payload byte
- REQ_ACK  out  NREQ  one-cycle pulse: byte taken, present next
- GNT  out  NREQ  one-hot, held for the whole packet
- ACTIVE  out  1  packet in progress
- ERR  out  1  sticky: START timeout or MAX_LEN overrun
- TX_START  out  1  to transmitter START
- TX_DATA  out  8  to transmitter DATA
- TX_BUSY  in  1  from transmitter BUSY (changes on falling CLK edge)

## Operation
- Reset: all outputs 0; RR pointer 0 (requester 0 has highest priority first); checksum 0; state IDLE.
- States: IDLE, HDR, PAY_WAIT, SEND_S, SEND_B, CSUM, DONE.
- IDLE: grant only when TX_BUSY=0 and any REQ_VALID=1. Winner is the first valid index searching from RR pointer upward with wrap. Set GNT, ACTIVE; clear checksum; go to HDR.
- HDR: TX_DATA <= HDR_BASE|id, checksum <= that byte, TX_START <= 1; go to SEND_S.
- SEND_S: TX_START stays high until TX_BUSY=1 is sampled, then TX_START <= 0 and go to SEND_B. If START_TO cycles elapse without BUSY: TX_START <= 0, ERR <= 1, abort to DONE.
- SEND_B: wait for TX_BUSY=0. Then go to PAY_WAIT after the header or a non-last payload byte, to CSUM after the last payload byte, and to DONE after the checksum byte.
- PAY_WAIT: stall while REQ_VALID[g]=0; stalling is unbounded. When valid: TX_DATA <= REQ_DATA[g], checksum ^= byte, TX_START <= 1, REQ_ACK[g] <= 1 for one cycle. Record REQ_LAST[g] and increment the byte count; go to SEND_S.
- Overrun: if the byte count reaches MAX_LEN without LAST, treat that byte as last and set ERR. The requester's remaining bytes then start a new packet.
- CSUM: TX_DATA <= checksum, TX_START <= 1; go to SEND_S.
- DONE: clear GNT and ACTIVE; RR pointer <= g+1 (mod NREQ); go to IDLE.
- TX_START is never high while TX_BUSY=1 is already sampled; a held START would retrigger the transmitter.
- REQ_VALID/DATA/LAST of non-granted requesters are ignored. Only REQ_ACK[g] ever pulses.

## Timing
- All state changes occur on the rising CLK edge. RST_N clears state asynchronously and deasserts synchronously via a 2-flop synchronizer.
- Grant latency: REQ_VALID high at edge n → GNT/ACTIVE at n+1 → TX_START with header at n+2.
- TX_START stays high for 1 cycle in normal operation, because the transmitter raises BUSY on the intervening falling edge. It is never high for more than START_TO cycles.
- REQ_ACK high in the same cycle TX_START first rises for that payload byte. The requester advances its byte at the edge where it samples ACK=1.
- Per byte: about 10 bit periods of 10415 cycles each, plus 2 to 3 cycles of handshake. Packet = L+2 bytes.
- Reset mid-packet: outputs drop immediately and the packet is lost. The transmitter may still finish its byte; IDLE waits for TX_BUSY=0 before the next grant.

## Test plan
- Single packet: req 1 sends 0x11,0x22(LAST) → TX bytes A1,11,22,92; REQ_ACK[1] pulses twice; ACTIVE falls after the 4th BUSY fall.
- Round-robin: reqs 0 and 2 valid continuously, 1-byte packets → grant order 0,2,0,2; after req 3 is added, order 0,2,3,0.
- Stall: req 0 drops VALID for 50000 cycles between bytes → TX idle, GNT held, no extra ACK; resumes with correct checksum.
- Timeout: TX_BUSY tied 0 → TX_START high exactly START_TO cycles, ERR=1, GNT cleared, next requester served.
- Overrun: MAX_LEN=4, 6 bytes with no LAST → first packet of 4 payload bytes plus checksum, ERR=1; remaining 2 bytes sent in a new packet.
- Reset during SEND_B with TX_BUSY=1 → outputs 0 immediately; no grant until TX_BUSY=0, then a normal packet.
